// File: rtl/fht_pkg.sv
// Shared constants, FSM state type and bit-reversal helper for the FHT sequencer.
// Default sizes match fht_ctrl's parameter defaults; derived sizes come from the helpers.
package fht_pkg;

   localparam int unsigned A_BIT_DEF = 8;
   localparam int unsigned PIPE_DEF  = 4;
   localparam int unsigned BANK_SIZE = 1 << A_BIT_DEF;
   localparam int unsigned STAGES    = A_BIT_DEF + 1;
   localparam int unsigned STAGE_LEN = BANK_SIZE + PIPE_DEF;

   typedef enum logic [0:0] {
      StIdle,
      StRun
   } fht_state_e;

   function automatic int unsigned bank_size(input int unsigned a_bit);
      return 32'd1 << a_bit;
   endfunction

   function automatic int unsigned stage_len(input int unsigned a_bit, input int unsigned pipe);
      return bank_size(a_bit) + pipe;
   endfunction

   // Reverses the low w bits of v; upper bits of the result are zero.
   function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned w);
      logic [31:0] r;
      r = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (i < w) begin
            r[i[4:0]] = v[5'(w - 1 - i)];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fht_addr_delay.sv
// Fixed-depth shift register that carries read-side values to the write side
// after the butterfly datapath latency.
module fht_addr_delay #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Width-1:0] pipe_q [Depth];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(Depth); i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         pipe_q[0] <= d_i;
         for (int i = 1; i < int'(Depth); i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign q_o = pipe_q[Depth-1];

endmodule

// File: rtl/fht_ctrl.sv
// Stage/time sequencer for an in-place ping-pong FHT over four banks per memory set.
// Define FHT_CTRL_REG_ADDR_EN to add one output register stage on every output.
module fht_ctrl
   import fht_pkg::*;
#(
   parameter int unsigned A_BIT = A_BIT_DEF,
   parameter int unsigned PIPE  = PIPE_DEF
) (
   input  logic             iCLK,
   input  logic             iRESET,
   input  logic             iSTART,
   output logic             oST_ZERO,
   output logic             oST_LAST,
   output logic             o2ND_PART_SUBSEC,
   output logic [A_BIT-1:0] oSECTOR,
   output logic [A_BIT-1:0] oADDR_RD_0,
   output logic [A_BIT-1:0] oADDR_RD_1,
   output logic [A_BIT-1:0] oADDR_RD_2,
   output logic [A_BIT-1:0] oADDR_RD_3,
   output logic [A_BIT-1:0] oADDR_WR_0,
   output logic [A_BIT-1:0] oADDR_WR_1,
   output logic [A_BIT-1:0] oADDR_WR_2,
   output logic [A_BIT-1:0] oADDR_WR_3,
   output logic [A_BIT-1:0] oADDR_COEF,
   output logic             oWE_A,
   output logic             oWE_B,
   output logic             oSOURCE_DATA,
   output logic             oSOURCE_CONT,
   output logic             oRDY
);

   localparam int unsigned BankSize = bank_size(A_BIT);
   localparam int unsigned StageLen = stage_len(A_BIT, PIPE);
   localparam int unsigned SW       = $clog2(A_BIT + 1);
   localparam int unsigned TW       = $clog2(StageLen);

   localparam logic [SW-1:0] StLast = SW'(A_BIT);
   localparam logic [TW-1:0] TLast  = TW'(StageLen - 1);
   localparam logic [TW-1:0] TBank  = TW'(BankSize);

   fht_state_e    state_q;
   logic [SW-1:0] cnt_stage;
   logic [TW-1:0] cnt_stage_time;
   logic          rdy_q;
   logic          cont_q;
   logic          busy;
   logic          rd_phase;

   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         state_q        <= StIdle;
         cnt_stage      <= '0;
         cnt_stage_time <= '0;
         rdy_q          <= 1'b1;
         cont_q         <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (iSTART) begin
                  state_q        <= StRun;
                  cnt_stage      <= '0;
                  cnt_stage_time <= '0;
                  rdy_q          <= 1'b0;
                  cont_q         <= 1'b1;
               end
            end
            StRun: begin
               if (cnt_stage_time == TLast) begin
                  cnt_stage_time <= '0;
                  if (cnt_stage == StLast) begin
                     state_q   <= StIdle;
                     cnt_stage <= '0;
                     rdy_q     <= 1'b1;
                     cont_q    <= 1'b0;
                  end else begin
                     cnt_stage <= cnt_stage + 1'b1;
                  end
               end else begin
                  cnt_stage_time <= cnt_stage_time + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy     = (state_q == StRun);
   assign rd_phase = busy && (cnt_stage_time < TBank);

   // One extra bit of headroom so M = 2^A_BIT is representable in the last stage.
   logic [A_BIT:0]   t_w;
   logic [A_BIT:0]   m_w;
   logic [A_BIT:0]   mask_w;
   logic [A_BIT:0]   off_w;
   logic [A_BIT:0]   mirror_w;
   logic [SW-1:0]    coef_sh;
   logic [A_BIT-1:0] rd01_c;
   logic [A_BIT-1:0] rd23_c;
   logic [A_BIT-1:0] sector_c;
   logic [A_BIT-1:0] coef_c;
   logic             second_c;

   always_comb begin
      t_w      = {1'b0, cnt_stage_time[A_BIT-1:0]};
      m_w      = {{A_BIT{1'b0}}, 1'b1} << cnt_stage;
      mask_w   = m_w - 1'b1;
      off_w    = t_w & mask_w;
      mirror_w = (t_w & ~mask_w) | ((m_w - off_w) & mask_w);
      coef_sh  = StLast - cnt_stage;
      rd01_c   = t_w[A_BIT-1:0];
      rd23_c   = mirror_w[A_BIT-1:0];
      sector_c = A_BIT'(t_w >> cnt_stage);
      second_c = (off_w >= (m_w >> 1));
      coef_c   = A_BIT'(off_w << coef_sh);
      if (cnt_stage == '0) begin
         rd01_c   = A_BIT'(bitrev(32'(t_w), A_BIT));
         rd23_c   = rd01_c;
         sector_c = '0;
         second_c = 1'b0;
         coef_c   = '0;
      end
   end

   // Last read-phase values, presented during drain and idle cycles.
   logic [A_BIT-1:0] rd01_q;
   logic [A_BIT-1:0] rd23_q;
   logic [A_BIT-1:0] sector_q;
   logic [A_BIT-1:0] coef_q;
   logic             second_q;

   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         rd01_q   <= '0;
         rd23_q   <= '0;
         sector_q <= '0;
         coef_q   <= '0;
         second_q <= 1'b0;
      end else if (rd_phase) begin
         rd01_q   <= rd01_c;
         rd23_q   <= rd23_c;
         sector_q <= sector_c;
         coef_q   <= coef_c;
         second_q <= second_c;
      end
   end

   logic [A_BIT-1:0] rd01;
   logic [A_BIT-1:0] rd23;
   logic [A_BIT-1:0] sector;
   logic [A_BIT-1:0] coef;
   logic             second;

   assign rd01   = rd_phase ? rd01_c   : rd01_q;
   assign rd23   = rd_phase ? rd23_c   : rd23_q;
   assign sector = rd_phase ? sector_c : sector_q;
   assign coef   = rd_phase ? coef_c   : coef_q;
   assign second = rd_phase ? second_c : second_q;

   logic [A_BIT-1:0] wr0;
   logic [A_BIT-1:0] wr1;
   logic [A_BIT-1:0] wr2;
   logic [A_BIT-1:0] wr3;
   logic [1:0]       we_info;

   fht_addr_delay #(.Width(A_BIT), .Depth(PIPE)) u_dly_wr0 (
      .clk_i  (iCLK),
      .rst_ni (iRESET),
      .d_i    (rd01),
      .q_o    (wr0)
   );

   fht_addr_delay #(.Width(A_BIT), .Depth(PIPE)) u_dly_wr1 (
      .clk_i  (iCLK),
      .rst_ni (iRESET),
      .d_i    (rd01),
      .q_o    (wr1)
   );

   fht_addr_delay #(.Width(A_BIT), .Depth(PIPE)) u_dly_wr2 (
      .clk_i  (iCLK),
      .rst_ni (iRESET),
      .d_i    (rd23),
      .q_o    (wr2)
   );

   fht_addr_delay #(.Width(A_BIT), .Depth(PIPE)) u_dly_wr3 (
      .clk_i  (iCLK),
      .rst_ni (iRESET),
      .d_i    (rd23),
      .q_o    (wr3)
   );

   // A valid read plus its stage parity lands on the write side within the same stage.
   fht_addr_delay #(.Width(2), .Depth(PIPE)) u_dly_we (
      .clk_i  (iCLK),
      .rst_ni (iRESET),
      .d_i    ({rd_phase, cnt_stage[0]}),
      .q_o    (we_info)
   );

   logic st_zero_c;
   logic st_last_c;
   logic src_data_c;
   logic we_a_c;
   logic we_b_c;

   assign st_zero_c  = busy && (cnt_stage == '0);
   assign st_last_c  = busy && (cnt_stage == StLast);
   assign src_data_c = busy && cnt_stage[0];
   assign we_a_c     = we_info[1] && we_info[0];
   assign we_b_c     = we_info[1] && !we_info[0];

`ifdef FHT_CTRL_REG_ADDR_EN
   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         oST_ZERO         <= 1'b0;
         oST_LAST         <= 1'b0;
         o2ND_PART_SUBSEC <= 1'b0;
         oSECTOR          <= '0;
         oADDR_RD_0       <= '0;
         oADDR_RD_1       <= '0;
         oADDR_RD_2       <= '0;
         oADDR_RD_3       <= '0;
         oADDR_WR_0       <= '0;
         oADDR_WR_1       <= '0;
         oADDR_WR_2       <= '0;
         oADDR_WR_3       <= '0;
         oADDR_COEF       <= '0;
         oWE_A            <= 1'b0;
         oWE_B            <= 1'b0;
         oSOURCE_DATA     <= 1'b0;
         oSOURCE_CONT     <= 1'b0;
         oRDY             <= 1'b1;
      end else begin
         oST_ZERO         <= st_zero_c;
         oST_LAST         <= st_last_c;
         o2ND_PART_SUBSEC <= second;
         oSECTOR          <= sector;
         oADDR_RD_0       <= rd01;
         oADDR_RD_1       <= rd01;
         oADDR_RD_2       <= rd23;
         oADDR_RD_3       <= rd23;
         oADDR_WR_0       <= wr0;
         oADDR_WR_1       <= wr1;
         oADDR_WR_2       <= wr2;
         oADDR_WR_3       <= wr3;
         oADDR_COEF       <= coef;
         oWE_A            <= we_a_c;
         oWE_B            <= we_b_c;
         oSOURCE_DATA     <= src_data_c;
         oSOURCE_CONT     <= cont_q;
         oRDY             <= rdy_q;
      end
   end
`else
   assign oST_ZERO         = st_zero_c;
   assign oST_LAST         = st_last_c;
   assign o2ND_PART_SUBSEC = second;
   assign oSECTOR          = sector;
   assign oADDR_RD_0       = rd01;
   assign oADDR_RD_1       = rd01;
   assign oADDR_RD_2       = rd23;
   assign oADDR_RD_3       = rd23;
   assign oADDR_WR_0       = wr0;
   assign oADDR_WR_1       = wr1;
   assign oADDR_WR_2       = wr2;
   assign oADDR_WR_3       = wr3;
   assign oADDR_COEF       = coef;
   assign oWE_A            = we_a_c;
   assign oWE_B            = we_b_c;
   assign oSOURCE_DATA     = src_data_c;
   assign oSOURCE_CONT     = cont_q;
   assign oRDY             = rdy_q;
`endif

endmodule

// File: tb/tb_fht_ctrl.sv
// Bench for fht_ctrl at A_BIT=3, PIPE=4: cycle-indexed reference model plus literal
// sequences, with randomized start noise, idle gaps and a mid-conversion reset.
module tb_fht_ctrl;

   localparam int AB    = 3;
   localparam int PP    = 4;
   localparam int BS    = 8;
   localparam int L     = 12;
   localparam int NST   = 4;
   localparam int TOTAL = 48;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          st_zero, st_last, second, we_a, we_b, src_data, src_cont, rdy;
   logic [AB-1:0] sector, rd0, rd1, rd2, rd3, wr0, wr1, wr2, wr3, coef;

   always #5 clk = ~clk;

   fht_ctrl #(.A_BIT(AB), .PIPE(PP)) dut (
      .iCLK             (clk),
      .iRESET           (rst_n),
      .iSTART           (start),
      .oST_ZERO         (st_zero),
      .oST_LAST         (st_last),
      .o2ND_PART_SUBSEC (second),
      .oSECTOR          (sector),
      .oADDR_RD_0       (rd0),
      .oADDR_RD_1       (rd1),
      .oADDR_RD_2       (rd2),
      .oADDR_RD_3       (rd3),
      .oADDR_WR_0       (wr0),
      .oADDR_WR_1       (wr1),
      .oADDR_WR_2       (wr2),
      .oADDR_WR_3       (wr3),
      .oADDR_COEF       (coef),
      .oWE_A            (we_a),
      .oWE_B            (we_b),
      .oSOURCE_DATA     (src_data),
      .oSOURCE_CONT     (src_cont),
      .oRDY             (rdy)
   );

   int n_checks = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic for a read-phase cycle t of stage s.
   function automatic int ref_bitrev(input int v);
      int r = 0;
      for (int i = 0; i < AB; i++) if (((v >> i) & 1) != 0) r += 1 << (AB - 1 - i);
      return r;
   endfunction

   function automatic int ref_rd(input int s, input int t, input int bank);
      int m, off;
      if (s == 0) return ref_bitrev(t);
      if (bank < 2) return t;
      m   = 1 << s;
      off = t % m;
      return (t - off) + ((m - off) % m);
   endfunction

   function automatic int ref_sector(input int s, input int t);
      return (s == 0) ? 0 : t / (1 << s);
   endfunction

   function automatic int ref_second(input int s, input int t);
      return (s == 0) ? 0 : int'((t % (1 << s)) >= ((1 << s) / 2));
   endfunction

   function automatic int ref_coef(input int s, input int t);
      return (s == 0) ? 0 : (t % (1 << s)) * (BS / (1 << s));
   endfunction

   // Model state: busy flag and cycle index within the conversion.
   bit m_busy;
   bit m_fresh;
   int m_k;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy  <= 1'b0;
         m_fresh <= 1'b1;
         m_k     <= 0;
      end else if (!m_busy) begin
         if (start) begin
            m_busy  <= 1'b1;
            m_fresh <= 1'b0;
            m_k     <= 0;
         end
      end else if (m_k == TOTAL - 1) begin
         m_busy <= 1'b0;
         m_k    <= 0;
      end else begin
         m_k <= m_k + 1;
      end
   end

   int       cap_s0_rd [8];
   int       cap_s0_wr [8];
   int       cap_s2_rd2 [8];
   int       cap_s2_coef [8];
   int       cap_s3_rd2 [8];
   logic [7:0] cap_s2_2nd;
   int       wea_cnt [NST];
   int       web_cnt [NST];
   int       last_cnt;

   always @(negedge clk) begin : cmp
      int s, t, tr;
      s  = m_k / L;
      t  = m_k % L;
      tr = (t < BS) ? t : BS - 1;
      chk("rdy", rdy, !m_busy);
      chk("source_cont", src_cont, m_busy);
      chk("st_zero", st_zero, m_busy && s == 0);
      chk("st_last", st_last, m_busy && s == NST - 1);
      chk("source_data", src_data, m_busy && (s % 2) == 1);
      chk("we_b", we_b, m_busy && t >= PP && (s % 2) == 0);
      chk("we_a", we_a, m_busy && t >= PP && (s % 2) == 1);
      if (m_busy) begin
         chk("cnt_stage", dut.cnt_stage, s);
         chk("cnt_stage_time", dut.cnt_stage_time, t);
         chk("rd0", rd0, ref_rd(s, tr, 0));
         chk("rd1", rd1, ref_rd(s, tr, 1));
         chk("rd2", rd2, ref_rd(s, tr, 2));
         chk("rd3", rd3, ref_rd(s, tr, 3));
         chk("sector", sector, ref_sector(s, tr));
         chk("second", second, ref_second(s, tr));
         chk("coef", coef, ref_coef(s, tr));
         if (t >= PP) begin
            chk("wr0", wr0, ref_rd(s, t - PP, 0));
            chk("wr1", wr1, ref_rd(s, t - PP, 1));
            chk("wr2", wr2, ref_rd(s, t - PP, 2));
            chk("wr3", wr3, ref_rd(s, t - PP, 3));
         end
         if (s == 0 && t < BS) cap_s0_rd[t] = int'(rd0);
         if (s == 0 && t >= PP) cap_s0_wr[t - PP] = int'(wr0);
         if (s == 2 && t < BS) begin
            cap_s2_rd2[t]  = int'(rd2);
            cap_s2_coef[t] = int'(coef);
            cap_s2_2nd[t]  = second;
         end
         if (s == 3 && t < BS) cap_s3_rd2[t] = int'(rd2);
         wea_cnt[s] += int'(we_a);
         web_cnt[s] += int'(we_b);
         last_cnt   += int'(st_last);
      end else begin
         chk("cnt_stage_idle", dut.cnt_stage, 0);
         chk("cnt_stage_time_idle", dut.cnt_stage_time, 0);
      end
      if (m_fresh) begin
         chk("rst_rd0", rd0, 0);
         chk("rst_rd2", rd2, 0);
         chk("rst_wr0", wr0, 0);
         chk("rst_wr3", wr3, 0);
         chk("rst_coef", coef, 0);
         chk("rst_sector", sector, 0);
         chk("rst_second", second, 0);
      end
   end

   task automatic clear_caps();
      for (int i = 0; i < NST; i++) begin
         wea_cnt[i] = 0;
         web_cnt[i] = 0;
      end
      last_cnt = 0;
   endtask

   // Caller is at a negedge with the DUT idle; len counts busy cycles.
   task automatic run_conv(input bit noise, output int len);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      len = 0;
      while (rdy == 1'b0 && len < 200) begin
         if (noise) start = 1'($urandom_range(0, 1));
         @(negedge clk);
         len++;
      end
      start = 1'b0;
   endtask

   int lit_s0 [8]     = '{0, 4, 2, 6, 1, 5, 3, 7};
   int lit_s2_rd2 [8] = '{0, 3, 2, 1, 4, 7, 6, 5};
   int lit_s2_cf [8]  = '{0, 2, 4, 6, 0, 2, 4, 6};
   int lit_s3_rd2 [8] = '{0, 7, 6, 5, 4, 3, 2, 1};

   initial begin
      int len, k;
      // Start held high throughout reset must not launch a conversion.
      start = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_rdy", rdy, 1);
      chk("idle_we_b", we_b, 0);

      clear_caps();
      run_conv(1'b0, len);
      chk("busy_len", len, TOTAL);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("s0_rd0[%0d]", i), cap_s0_rd[i], lit_s0[i]);
         chk($sformatf("s0_wr0[%0d]", i), cap_s0_wr[i], lit_s0[i]);
         chk($sformatf("s2_rd2[%0d]", i), cap_s2_rd2[i], lit_s2_rd2[i]);
         chk($sformatf("s2_coef[%0d]", i), cap_s2_coef[i], lit_s2_cf[i]);
         chk($sformatf("s3_rd2[%0d]", i), cap_s3_rd2[i], lit_s3_rd2[i]);
      end
      chk("s2_2nd_pattern", cap_s2_2nd, 8'b1100_1100);
      chk("s0_we_b_cycles", web_cnt[0], 8);
      chk("s0_we_a_cycles", wea_cnt[0], 0);
      chk("s3_we_a_cycles", wea_cnt[3], 8);
      chk("s3_we_b_cycles", web_cnt[3], 0);
      chk("st_last_cycles", last_cnt, L);

      for (int r = 0; r < 5; r++) begin
         repeat ($urandom_range(0, 4)) @(negedge clk);
         run_conv(1'b1, len);
         chk("busy_len_noise", len, TOTAL);
      end

      // Asynchronous reset in the middle of stage 1.
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = $urandom_range(L, 2 * L - 1);
      repeat (k) @(negedge clk);
      chk("pre_rst_stage", dut.cnt_stage, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_rdy", rdy, 1);
      chk("arst_we_a", we_a, 0);
      chk("arst_we_b", we_b, 0);
      chk("arst_rd0", rd0, 0);
      chk("arst_rd2", rd2, 0);
      chk("arst_wr0", wr0, 0);
      chk("arst_cont", src_cont, 0);
      chk("arst_src_data", src_data, 0);
      chk("arst_cnt_stage", dut.cnt_stage, 0);
      chk("arst_cnt_time", dut.cnt_stage_time, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_conv(1'b0, len);
      chk("busy_len_after_rst", len, TOTAL);
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fht_ctrl.md
Name: fht_ctrl

Overview:
- Sequencer for an in-place, ping-pong Fast Hartley Transform over N = 4·2^A_BIT points held in four parallel RAM banks per memory set; two sets, A and B.
- After one iSTART pulse it walks A_BIT+1 stages and, per cycle, generates four read addresses, four write addresses, a twiddle-coefficient address, bank write enables and datapath steering flags.
- Sits between the host handshake (iSTART/oRDY) and the butterfly datapath plus bank memories.

Parameters:
- A_BIT, 8, bank address width; BANK_SIZE = 2^A_BIT.
- PIPE, 4, butterfly datapath latency in cycles from read address to write address.

Ports:
- iCLK  in  1  clock, rising edge.
- iRESET  in  1  asynchronous active-low reset.
- iSTART  in  1  start pulse, sampled only while oRDY=1.
- oST_ZERO  out  1  high during stage 0 (bit-reverse pass).
- oST_LAST  out  1  high during stage A_BIT.
- o2ND_PART_SUBSEC  out  1  current offset lies in the upper half of its sector.
- oSECTOR  out  A_BIT  current sector index.
- oADDR_RD_0..3  out  A_BIT each  read addresses, banks 0..3.
- oADDR_WR_0..3  out  A_BIT each  write addresses, banks 0..3.
- oADDR_COEF  out  A_BIT  twiddle ROM address.
- oWE_A  out  1  write enable, memory set A.
- oWE_B  out  1  write enable, memory set B.
- oSOURCE_DATA  out  1  read-set select: 0 = A, 1 = B.
- oSOURCE_CONT  out  1  1 = banks addressed by this block; 0 = external load/unload.
- oRDY  out  1  1 = idle/done, 0 = busy.

Behaviour:
- Internal registers named cnt_stage (0..A_BIT) and cnt_stage_time (0..BANK_SIZE+PIPE-1); the bench probes both hierarchically.
- Reset: all counters 0; oRDY=1; oWE_A=oWE_B=0; all addresses, oSECTOR and all flags 0.
- Idle: iSTART=1 at a rising edge with oRDY=1 → next cycle oRDY=0, oSOURCE_CONT=1, cnt_stage=0, cnt_stage_time=0.
- iSTART while busy is ignored.
- Stage length L = BANK_SIZE+PIPE cycles. cnt_stage_time counts 0..L-1, then wraps to 0 and cnt_stage increments.
- After the final cycle of stage A_BIT: oRDY=1, oSOURCE_CONT=0, counters 0. Total busy time = (A_BIT+1)·L cycles.
- Read phase (t = cnt_stage_time < BANK_SIZE):
  - Stage 0: all four read addresses = bitrev(t, A_BIT).
  - Stage s ≥ 1, with M = 2^s, base = t & ~(M-1), off = t & (M-1):
  - RD_0 = RD_1 = t.
  - RD_2 = RD_3 = base | ((M - off) mod M).
  - oSECTOR = t >> s; o2ND_PART_SUBSEC = (off ≥ M/2); oADDR_COEF = off << (A_BIT - s).
  - Stage 0: oSECTOR, o2ND_PART_SUBSEC and oADDR_COEF = 0.
- Drain cycles (t ≥ BANK_SIZE): read-side outputs hold their last values.
- Write side:
  - Write addresses = read addresses delayed by exactly PIPE cycles, per bank.
  - Write enable is high for exactly BANK_SIZE cycles per stage, t = PIPE..L-1.
  - Even stages: read A, write B (oWE_B), oSOURCE_DATA=0.
  - Odd stages: read B, write A (oWE_A), oSOURCE_DATA=1.
  - oWE_A and oWE_B are never high together.
- Stage flags: oST_ZERO=(cnt_stage==0) and oST_LAST=(cnt_stage==A_BIT), both gated by busy. When idle, both flags = 0.
- Reset mid-conversion: immediate return to the reset state; no further writes.

Optional Feature:
- Macro: FHT_CTRL_REG_ADDR_EN.
- Defined:
  - Every address, flag and write-enable output passes through one extra output register.
  - All outputs shift one cycle later relative to the counters.
  - oRDY also rises one cycle later.
  - The RD-to-WR relationship stays PIPE cycles.
- Undefined: outputs are driven directly from the counter logic, as specified above.

Decomposition:
- Package fht_pkg: BANK_SIZE, STAGES = A_BIT+1, stage length L, and a bitrev function.
- Sub-module fht_addr_delay: a PIPE-deep shift register instantiated per write address plus the write-enable qualifier.

Test Plan (A_BIT=3, PIPE=4 → BANK_SIZE=8, L=12, 4 stages):
- Reset then idle → oRDY=1, oWE_A=oWE_B=0, all addresses 0; iSTART while in reset has no effect.
- One-cycle iSTART → oRDY falls next cycle and rises after exactly 48 cycles.
- Stage 0 → RD_0..3 sequence 0,4,2,6,1,5,3,7; WR sequence identical, 4 cycles later; oWE_B high for 8 cycles; oST_ZERO=1.
- Stage 2 (M=4) → RD_2 sequence 0,3,2,1,4,7,6,5; oADDR_COEF sequence 0,2,4,6,0,2,4,6; o2ND_PART_SUBSEC=1 at t=2,3,6,7.
- Stage 3 → oST_LAST=1, oWE_A pulses only, RD_2 sequence 0,7,6,5,4,3,2,1, oSECTOR=0 throughout.
- iSTART pulse mid-conversion → ignored, total time still 48 cycles; iRESET low mid-stage-1 → outputs return to reset values on the same edge.
